// File: rtl/mem_bus_master.sv
// mem_bus_master: cache-side initiator for the main-memory bus.
// Takes one request at a time, arbitrates for the bus, then issues either a
// two-beat 32-byte line fill or a single 1..4 byte store. All bus-facing and
// handshake outputs are registered from the next-state decode, so they are
// stable for the whole beat.
module mem_bus_master #(
   parameter logic [2:0]  SRC_ID  = 3'd1,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic         REQ_VALID,
   output logic         REQ_READY,
   input  logic         REQ_WR,
   input  logic [14:0]  REQ_ADDR,
   input  logic [2:0]   REQ_SIZE,
   input  logic [31:0]  REQ_WDATA,
   output logic         RSP_VALID,
   output logic         RSP_ERR,
   output logic [255:0] RSP_RDATA,
   output logic         BUS_REQ,
   input  logic         BUS_GNT,
   output logic [14:0]  MEM_ADDR,
   output logic         MEM_WR,
   output logic         MEM_EN,
   output logic [2:0]   MEM_WRITE_SIZE,
   output logic [2:0]   MEM_SRC,
   output logic [127:0] MEM_WDATA,
   input  logic [127:0] MEM_RDATA
);

   typedef enum logic [2:0] {IDLE, ARB, RD0, RD1, WRB, RSP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic          lat_wr, lat_err, err_nxt, accept;
   logic [14:0]   lat_addr;
   logic [2:0]    lat_size;
   logic [31:0]   lat_wdata;
   logic          cap_lo, cap_hi;
   logic          ready_nxt, bus_req_nxt, en_nxt, wr_nxt, rsp_valid_nxt, rsp_err_nxt;
   logic [14:0]   addr_nxt;
   logic [2:0]    size_nxt;
   logic [127:0]  wdata_nxt;

   assign MEM_SRC = SRC_ID;

   // next-state, beat counter and next values of the registered outputs
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      err_nxt       = lat_err;
      accept        = 1'b0;
      cap_lo        = 1'b0;
      cap_hi        = 1'b0;
      case (state)
         IDLE: begin
            if (REQ_VALID) begin
               accept  = 1'b1;
               err_nxt = REQ_WR && !((REQ_SIZE >= 3'd1) && (REQ_SIZE <= 3'd4));
               state_nxt = err_nxt ? RSP : ARB;
            end
         end
         ARB: begin
            if (BUS_GNT) begin
               cnt_nxt   = LAT_M1;
               state_nxt = lat_wr ? WRB : RD0;
            end
         end
         RD0: begin
            if (cnt == 4'd0) begin
               cap_lo    = 1'b1;
               cnt_nxt   = LAT_M1;
               state_nxt = RD1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RD1: begin
            if (cnt == 4'd0) begin
               cap_hi    = 1'b1;
               state_nxt = RSP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         WRB: begin
            if (cnt == 4'd0) state_nxt = RSP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RSP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // outputs decoded from the state being entered, then registered below
      ready_nxt     = (state_nxt == IDLE);
      bus_req_nxt   = (state_nxt == ARB) || (state_nxt == RD0) ||
                      (state_nxt == RD1) || (state_nxt == WRB);
      en_nxt        = (state_nxt == RD0) || (state_nxt == RD1) || (state_nxt == WRB);
      wr_nxt        = (state_nxt == WRB);
      rsp_valid_nxt = (state_nxt == RSP);
      rsp_err_nxt   = (state_nxt == RSP) && err_nxt;
      addr_nxt      = '0;
      size_nxt      = '0;
      wdata_nxt     = '0;
      case (state_nxt)
         RD0: addr_nxt = {lat_addr[14:5], 5'b00000};
         RD1: addr_nxt = {lat_addr[14:5], 5'b10000};
         WRB: begin
            addr_nxt  = lat_addr;
            size_nxt  = lat_size;
            wdata_nxt = {96'b0, lat_wdata};
         end
         default: ;
      endcase
   end

   // state, counter and request latch
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_wr    <= 1'b0;
         lat_err   <= 1'b0;
         lat_addr  <= '0;
         lat_size  <= '0;
         lat_wdata <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         lat_err <= err_nxt;
         if (accept) begin
            lat_wr    <= REQ_WR;
            lat_addr  <= REQ_ADDR;
            lat_size  <= REQ_SIZE;
            lat_wdata <= REQ_WDATA;
         end
      end
   end

   // registered handshake and bus outputs
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         REQ_READY      <= 1'b1;
         BUS_REQ        <= 1'b0;
         MEM_EN         <= 1'b0;
         MEM_WR         <= 1'b0;
         MEM_ADDR       <= '0;
         MEM_WRITE_SIZE <= '0;
         MEM_WDATA      <= '0;
         RSP_VALID      <= 1'b0;
         RSP_ERR        <= 1'b0;
      end else begin
         REQ_READY      <= ready_nxt;
         BUS_REQ        <= bus_req_nxt;
         MEM_EN         <= en_nxt;
         MEM_WR         <= wr_nxt;
         MEM_ADDR       <= addr_nxt;
         MEM_WRITE_SIZE <= size_nxt;
         MEM_WDATA      <= wdata_nxt;
         RSP_VALID      <= rsp_valid_nxt;
         RSP_ERR        <= rsp_err_nxt;
      end
   end

   // line-fill capture at the last cycle of each read beat; held otherwise
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         RSP_RDATA <= '0;
      end else begin
         if (cap_lo) RSP_RDATA[127:0]   <= MEM_RDATA;
         if (cap_hi) RSP_RDATA[255:128] <= MEM_RDATA;
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: two instances (MEM_LAT=2/SRC_ID=1 and MEM_LAT=1/SRC_ID=2)
// share the request inputs; a byte-array memory responder serves both, and a
// transaction-level model predicts every bus cycle and the response.
`timescale 1ns/1ps
module tb_mem_bus_master;

   typedef struct packed {
      logic        wr;
      logic [14:0] a;
      logic [2:0]  sz;
      logic [31:0] wd;
   } req_t;

   logic         CLK = 1'b0;
   logic         CLR, REQ_VALID, REQ_WR, BUS_GNT;
   logic [14:0]  REQ_ADDR;
   logic [2:0]   REQ_SIZE;
   logic [31:0]  REQ_WDATA;

   logic         rdy [2];
   logic         rspv [2];
   logic         rspe [2];
   logic         breq [2];
   logic         mwr [2];
   logic         men [2];
   logic [255:0] rdat [2];
   logic [14:0]  maddr [2];
   logic [2:0]   mws [2];
   logic [2:0]   msrc [2];
   logic [127:0] mwd [2];
   logic [127:0] mrd [2];

   logic [7:0]   resp_mem [32768];
   logic [7:0]   ref_mem [32768];
   logic [255:0] ref_line;
   bit           sel;
   int unsigned  n_chk, n_fail;

   always #5 CLK = ~CLK;

   mem_bus_master #(.SRC_ID(3'd1), .MEM_LAT(2)) dut (
      .CLK(CLK), .CLR(CLR), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[0]), .REQ_WR(REQ_WR),
      .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(rspv[0]), .RSP_ERR(rspe[0]), .RSP_RDATA(rdat[0]),
      .BUS_REQ(breq[0]), .BUS_GNT(BUS_GNT), .MEM_ADDR(maddr[0]), .MEM_WR(mwr[0]),
      .MEM_EN(men[0]), .MEM_WRITE_SIZE(mws[0]), .MEM_SRC(msrc[0]),
      .MEM_WDATA(mwd[0]), .MEM_RDATA(mrd[0]));

   mem_bus_master #(.SRC_ID(3'd2), .MEM_LAT(1)) dut1 (
      .CLK(CLK), .CLR(CLR), .REQ_VALID(REQ_VALID), .REQ_READY(rdy[1]), .REQ_WR(REQ_WR),
      .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(rspv[1]), .RSP_ERR(rspe[1]), .RSP_RDATA(rdat[1]),
      .BUS_REQ(breq[1]), .BUS_GNT(BUS_GNT), .MEM_ADDR(maddr[1]), .MEM_WR(mwr[1]),
      .MEM_EN(men[1]), .MEM_WRITE_SIZE(mws[1]), .MEM_SRC(msrc[1]),
      .MEM_WDATA(mwd[1]), .MEM_RDATA(mrd[1]));

   // memory responder: initial contents byte = low address byte; stores from the selected instance
   initial begin
      for (int a = 0; a < 32768; a++) resp_mem[a] = 8'(a);
      forever begin
         @(posedge CLK);
         if (men[sel] === 1'b1 && mwr[sel] === 1'b1)
            for (int k = 0; k < 4; k++)
               if (k < int'(mws[sel])) resp_mem[15'(maddr[sel] + 15'(k))] = mwd[sel][8*k +: 8];
      end
   end

   // read data: 16 bytes from the presented address, refreshed mid-cycle
   initial begin
      logic [127:0] t;
      mrd[0] = '0;
      mrd[1] = '0;
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 16; b++) t[8*b +: 8] = resp_mem[15'(maddr[i] + 15'(b))];
            mrd[i] = t;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      CLR = 1'b1; REQ_VALID = 1'b0; REQ_WR = 1'b0; BUS_GNT = 1'b0;
      REQ_ADDR = '0; REQ_SIZE = '0; REQ_WDATA = '0;
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
      ref_line = '0;
   endtask

   // one transaction: predicts every cycle from accept through the idle cycle after RSP
   task automatic run_txn(input req_t r, input bit chained, input int unsigned gdly,
                          input bit drop, input bit has_next, input req_t nx);
      int unsigned  lat, n0, nrsp, bidx;
      bit           err, beat;
      logic [14:0]  base, e_addr;
      logic [255:0] exp_line, e_line;
      logic [5:0]   e_ctl, a_ctl;
      logic [2:0]   e_ws;
      logic [127:0] e_wd;
      lat  = sel ? 1 : 2;
      err  = r.wr && !(r.sz >= 3'd1 && r.sz <= 3'd4);
      n0   = gdly + 2;
      nrsp = err ? 1 : (r.wr ? n0 + lat : n0 + 2*lat);
      base = {r.a[14:5], 5'b0};
      for (int k = 0; k < 32; k++) exp_line[8*k +: 8] = ref_mem[15'(base + 15'(k))];
      if (!err && r.wr)
         for (int k = 0; k < 4; k++)
            if (k < int'(r.sz)) ref_mem[15'(r.a + 15'(k))] = r.wd[8*k +: 8];
      e_line = (!err && !r.wr) ? exp_line : ref_line;
      BUS_GNT = 1'b0;
      if (!chained) begin
         @(negedge CLK);
         REQ_VALID = 1'b1; REQ_WR = r.wr; REQ_ADDR = r.a; REQ_SIZE = r.sz; REQ_WDATA = r.wd;
         n_chk++;
         if (rdy[sel] !== 1'b1) begin
            n_fail++; $display("FAIL ready_before_issue: got %b expected 1", rdy[sel]);
         end
      end
      @(posedge CLK);
      for (int unsigned n = 1; n <= nrsp + 1; n++) begin
         @(negedge CLK);
         if (n == 1) begin
            if (has_next) begin
               REQ_VALID = 1'b1; REQ_WR = nx.wr; REQ_ADDR = nx.a; REQ_SIZE = nx.sz; REQ_WDATA = nx.wd;
            end else begin
               REQ_VALID = 1'b0; REQ_WR = 1'($urandom); REQ_ADDR = 15'($urandom);
               REQ_SIZE = 3'($urandom); REQ_WDATA = $urandom;
            end
         end
         if (n <= gdly + 1) BUS_GNT = (n == gdly + 1);
         else               BUS_GNT = drop ? 1'b0 : 1'($urandom);
         beat   = !err && (n >= n0) && (n < nrsp);
         bidx   = beat ? (n - n0) / lat : 0;
         e_addr = beat ? (r.wr ? r.a : (base | ((bidx != 0) ? 15'h10 : 15'h0))) : 15'h0;
         e_ws   = (beat && r.wr) ? r.sz : 3'b0;
         e_wd   = (beat && r.wr) ? {96'b0, r.wd} : 128'b0;
         e_ctl  = {n == nrsp + 1, n == nrsp, (n == nrsp) && err, !err && (n < nrsp), beat, beat && r.wr};
         a_ctl  = {rdy[sel], rspv[sel], rspe[sel], breq[sel], men[sel], mwr[sel]};
         n_chk++;
         if (a_ctl !== e_ctl) begin
            n_fail++;
            $display("FAIL ctl cyc%0d addr=%h wr=%b: got rdy/v/err/breq/en/wr=%b expected %b",
                     n, r.a, r.wr, a_ctl, e_ctl);
         end
         n_chk++;
         if (maddr[sel] !== e_addr) begin
            n_fail++; $display("FAIL mem_addr cyc%0d: got %h expected %h", n, maddr[sel], e_addr);
         end
         n_chk++;
         if (mws[sel] !== e_ws || mwd[sel] !== e_wd) begin
            n_fail++;
            $display("FAIL wsize/wdata cyc%0d: got %b/%h expected %b/%h", n, mws[sel], mwd[sel], e_ws, e_wd);
         end
         if (n >= nrsp || r.wr) begin
            n_chk++;
            if (rdat[sel] !== e_line) begin
               n_fail++; $display("FAIL rsp_rdata cyc%0d: got %h expected %h", n, rdat[sel], e_line);
            end
         end
      end
      ref_line = e_line;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if ({rdy[i], rspv[i], rspe[i], breq[i], men[i], mwr[i]} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctl inst%0d: got %b expected 100000", i,
                     {rdy[i], rspv[i], rspe[i], breq[i], men[i], mwr[i]});
         end
         n_chk++;
         if (maddr[i] !== 15'h0 || mws[i] !== 3'b0 || mwd[i] !== 128'b0 || rdat[i] !== 256'b0) begin
            n_fail++; $display("FAIL reset_data inst%0d: got addr=%h ws=%b wd=%h", i, maddr[i], mws[i], mwd[i]);
         end
         n_chk++;
         if (msrc[i] !== ((i == 0) ? 3'd1 : 3'd2)) begin
            n_fail++; $display("FAIL mem_src inst%0d: got %0d expected %0d", i, msrc[i], (i == 0) ? 1 : 2);
         end
      end
   endtask

   task automatic test_reset_mid_rd1();
      logic [14:0] a;
      sel = 1'b0;
      do_reset();
      a = 15'($urandom);
      @(negedge CLK);
      REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = a; REQ_SIZE = 3'b0; BUS_GNT = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      n_chk++;
      if (men[0] !== 1'b1 || maddr[0] !== {a[14:5], 5'b10000}) begin
         n_fail++; $display("FAIL in_rd1: got en=%b addr=%h expected 1/%h", men[0], maddr[0], {a[14:5], 5'b10000});
      end
      CLR = 1'b1;
      #1;
      n_chk++;
      if ({rdy[0], rspv[0], breq[0], men[0]} !== 4'b1000 || rdat[0] !== 256'b0) begin
         n_fail++;
         $display("FAIL clr_mid_rd1: got rdy/v/breq/en=%b rdata=%h expected 1000 and 0",
                  {rdy[0], rspv[0], breq[0], men[0]}, rdat[0]);
      end
      @(negedge CLK);
      CLR = 1'b0;
      BUS_GNT = 1'b0;
      ref_line = '0;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         n_chk++;
         if (rspv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_fail++; $display("FAIL after_clr cyc%0d: got v=%b rdy=%b expected 0/1", c, rspv[0], rdy[0]);
         end
      end
   endtask

   task automatic test_directed_read();
      logic [255:0] want;
      sel = 1'b0;
      run_txn('{wr:1'b0, a:15'h1234, sz:3'b0, wd:32'h0}, 1'b0, 0, 1'b0, 1'b0, '0);
      for (int k = 0; k < 32; k++) want[8*k +: 8] = 8'(8'h20 + k);
      n_chk++;
      if (rdat[0] !== want) begin
         n_fail++; $display("FAIL line_1234: got %h expected %h", rdat[0], want);
      end
   endtask

   task automatic test_write();
      sel = 1'b0;
      run_txn('{wr:1'b1, a:15'h0043, sz:3'b010, wd:32'hAABB_CCDD}, 1'b0, 0, 1'b0, 1'b0, '0);
      run_txn('{wr:1'b0, a:15'h0040, sz:3'b0, wd:32'h0}, 1'b0, 0, 1'b0, 1'b0, '0);
      n_chk++;
      if (rdat[0][47:24] !== 24'h45_CC_DD) begin
         n_fail++; $display("FAIL readback_43: got bytes5..3=%h expected 45ccdd", rdat[0][47:24]);
      end
   endtask

   task automatic test_err_size();
      logic [2:0] bad [4];
      bad[0] = 3'b000; bad[1] = 3'b101; bad[2] = 3'b110; bad[3] = 3'b111;
      sel = 1'b0;
      for (int i = 0; i < 4; i++)
         run_txn('{wr:1'b1, a:15'($urandom), sz:bad[i], wd:$urandom}, 1'b0, 0, 1'b0, 1'b0, '0);
      run_txn('{wr:1'b0, a:15'($urandom), sz:3'b111, wd:32'h0}, 1'b0, 0, 1'b0, 1'b0, '0);
   endtask

   task automatic test_gnt_wait();
      sel = 1'b0;
      run_txn('{wr:1'b0, a:15'($urandom), sz:3'b0, wd:32'h0}, 1'b0, 10, 1'b1, 1'b0, '0);
      run_txn('{wr:1'b1, a:15'($urandom), sz:3'b100, wd:$urandom}, 1'b0, 10, 1'b1, 1'b0, '0);
   endtask

   task automatic test_back_to_back();
      req_t rd, wr, rd2;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         do_reset();
         rd  = '{wr:1'b0, a:15'($urandom), sz:3'b0, wd:32'h0};
         wr  = '{wr:1'b1, a:15'($urandom), sz:3'b011, wd:$urandom};
         rd2 = '{wr:1'b0, a:wr.a, sz:3'b0, wd:32'h0};
         run_txn(rd,  1'b0, 0, 1'b0, 1'b1, wr);
         run_txn(wr,  1'b1, 1, 1'b0, 1'b1, rd2);
         run_txn(rd2, 1'b1, 0, 1'b0, 1'b0, '0);
      end
   endtask

   task automatic test_random();
      req_t q [30];
      bit   ch [30];
      bit   prev;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         do_reset();
         for (int i = 0; i < 30; i++) begin
            q[i].wr = 1'($urandom);
            q[i].a  = 15'($urandom);
            q[i].sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4));
            q[i].wd = $urandom;
            ch[i]   = 1'($urandom);
         end
         prev = 1'b0;
         for (int i = 0; i < 30; i++) begin
            run_txn(q[i], prev, $urandom_range(0, 3), 1'($urandom), (i < 29) && ch[i],
                    (i < 29) ? q[i+1] : q[i]);
            prev = (i < 29) && ch[i];
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      sel = 1'b0;
      ref_line = '0;
      for (int a = 0; a < 32768; a++) ref_mem[a] = 8'(a);
      test_reset();
      test_reset_mid_rd1();
      test_directed_read();
      test_write();
      test_err_size();
      test_gnt_wait();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
